// File: rtl/adc_serial_pkg.sv
// rtl/adc_serial_pkg.sv - shared state type, width helper and default frame constants for adc_serial_capture
package adc_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_QUIET = 2'd2
    } state_e;

    localparam int DEF_NCH        = 1;
    localparam int DEF_DATA_W     = 12;
    localparam int DEF_FRAME_BITS = 14;
    localparam int DEF_SCLK_DIV   = 1;
    localparam int DEF_QUIET_CYC  = 4;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_shift_lane.sv
// rtl/adc_shift_lane.sv - one SDATA lane: serial shift register plus registered result slice
module adc_shift_lane
    import adc_serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              shift_en_i,
    input  logic              capture_i,
    input  logic              sdata_i,
    output logic [DATA_W-1:0] data_o
);

    // Only the last DATA_W bits of a frame are kept, so leading bits fall off the top.
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        sr_d   = sr_q;
        data_d = data_q;
        if (shift_en_i) begin
            sr_d = (sr_q << 1) | DATA_W'(sdata_i);
        end
        if (capture_i) begin
            data_d = sr_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q   <= '0;
            data_q <= '0;
        end else begin
            sr_q   <= sr_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/adc_serial_capture.sv
// rtl/adc_serial_capture.sv - CSn/SCLK generator and frame FSM capturing NCH serial ADC lanes
module adc_serial_capture
    import adc_serial_pkg::*;
#(
    parameter int NCH        = DEF_NCH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int SCLK_DIV   = DEF_SCLK_DIV,
    parameter int QUIET_CYC  = DEF_QUIET_CYC
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cont_en,
    input  logic                  trig,
    output logic                  busy,
    output logic                  overrun,
    output logic                  adc_csn,
    output logic                  adc_sclk,
    input  logic [NCH-1:0]        adc_sdata,
    output logic                  adc_data_en,
    output logic [NCH*DATA_W-1:0] adc_data
);

    localparam int H_W   = cnt_w(2*FRAME_BITS);
    localparam int DIV_W = cnt_w(SCLK_DIV+1);
    localparam int Q_W   = cnt_w(QUIET_CYC+1);

    localparam logic [H_W-1:0]   H_LAST   = H_W'(2*FRAME_BITS-1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV-1);
    localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET_CYC-1);

    if (FRAME_BITS < DATA_W || SCLK_DIV < 1 || QUIET_CYC < 1) begin : g_bad_params
        $error("adc_serial_capture: need FRAME_BITS>=DATA_W, SCLK_DIV>=1, QUIET_CYC>=1");
    end

    state_e           state_q, state_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [Q_W-1:0]   quiet_q, quiet_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             csn_q, csn_d;
    logic             sclk_q, sclk_d;
    logic             data_en_q, data_en_d;
    logic             shift_en, capture, launch;
    logic             trig_req;

    // A trigger during continuous mode is already covered by the next frame.
    assign trig_req = trig & ~cont_en;

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        div_d     = div_q;
        quiet_d   = quiet_q;
        pending_d = pending_q;
        csn_d     = csn_q;
        sclk_d    = sclk_q;
        overrun_d = 1'b0;
        data_en_d = 1'b0;
        shift_en  = 1'b0;
        capture   = 1'b0;
        launch    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                csn_d  = 1'b1;
                sclk_d = 1'b1;
                if (cont_en | trig) begin
                    launch = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (trig_req) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!h_q[0]) begin
                        shift_en = 1'b1;
                        sclk_d   = 1'b0;
                        h_d      = h_q + H_W'(1);
                    end else if (h_q == H_LAST) begin
                        csn_d     = 1'b1;
                        sclk_d    = 1'b1;
                        data_en_d = 1'b1;
                        capture   = 1'b1;
                        quiet_d   = '0;
                        state_d   = ST_QUIET;
                    end else begin
                        sclk_d = 1'b1;
                        h_d    = h_q + H_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_QUIET: begin
                if (quiet_q == Q_LAST) begin
                    if (cont_en | pending_q | trig) begin
                        launch    = 1'b1;
                        pending_d = 1'b0;
                        if (trig_req & pending_q) overrun_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    quiet_d = quiet_q + Q_W'(1);
                    if (trig_req) begin
                        if (pending_q) overrun_d = 1'b1;
                        else           pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_QUIET;
                quiet_d = '0;
            end
        endcase

        if (launch) begin
            state_d = ST_SHIFT;
            csn_d   = 1'b0;
            sclk_d  = 1'b1;
            h_d     = '0;
            div_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_QUIET;
            h_q       <= '0;
            div_q     <= '0;
            quiet_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            csn_q     <= 1'b1;
            sclk_q    <= 1'b1;
            data_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            div_q     <= div_d;
            quiet_q   <= quiet_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            csn_q     <= csn_d;
            sclk_q    <= sclk_d;
            data_en_q <= data_en_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        adc_shift_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk        (clk),
            .rstn       (rstn),
            .shift_en_i (shift_en),
            .capture_i  (capture),
            .sdata_i    (adc_sdata[i]),
            .data_o     (adc_data[i*DATA_W +: DATA_W])
        );
    end

    assign busy        = (state_q != ST_IDLE);
    assign overrun     = overrun_q;
    assign adc_csn     = csn_q;
    assign adc_sclk    = sclk_q;
    assign adc_data_en = data_en_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// tb/tb_adc_serial_capture.sv - directed self-checking bench for adc_serial_capture
module tb_adc_serial_capture;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cont_en_a, trig_a, busy_a, overrun_a, csn_a, sclk_a, data_en_a;
    logic [0:0]  sdata_a;
    logic [11:0] data_a;
    logic        cont_en_b, trig_b, busy_b, overrun_b, csn_b, sclk_b, data_en_b;
    logic [1:0]  sdata_b;
    logic [23:0] data_b;

    logic [13:0] word_a;
    logic [13:0] word_b0, word_b1;
    int          idx_a, idx_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_a = 0, ovr_a = 0, prev_va = 0, last_va = 0, run_a = 0, last_run_a = 0;
    int valid_b = 0, prev_vb = 0, last_vb = 0, srun_b = 0, last_srun_b = 0;

    always #5 clk = ~clk;

    adc_serial_capture u_dut_a (
        .clk         (clk),
        .rstn        (rstn),
        .cont_en     (cont_en_a),
        .trig        (trig_a),
        .busy        (busy_a),
        .overrun     (overrun_a),
        .adc_csn     (csn_a),
        .adc_sclk    (sclk_a),
        .adc_sdata   (sdata_a),
        .adc_data_en (data_en_a),
        .adc_data    (data_a)
    );

    adc_serial_capture #(.NCH(2), .SCLK_DIV(2)) u_dut_b (
        .clk         (clk),
        .rstn        (rstn),
        .cont_en     (cont_en_b),
        .trig        (trig_b),
        .busy        (busy_b),
        .overrun     (overrun_b),
        .adc_csn     (csn_b),
        .adc_sclk    (sclk_b),
        .adc_sdata   (sdata_b),
        .adc_data_en (data_en_b),
        .adc_data    (data_b)
    );

    // ADC models: MSB presented at CSn fall, next bit after each SCLK fall.
    always @(negedge csn_a or negedge sclk_a) begin
        if (sclk_a) idx_a = 13;
        else if (idx_a > 0) idx_a = idx_a - 1;
        sdata_a = word_a[idx_a];
    end

    always @(negedge csn_b or negedge sclk_b) begin
        if (sclk_b) idx_b = 13;
        else if (idx_b > 0) idx_b = idx_b - 1;
        sdata_b = {word_b1[idx_b], word_b0[idx_b]};
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_en_a === 1'b1) begin
            valid_a = valid_a + 1;
            prev_va = last_va;
            last_va = cyc;
        end
        if (overrun_a === 1'b1) ovr_a = ovr_a + 1;
        if (csn_a === 1'b0) run_a = run_a + 1;
        else if (run_a != 0) begin
            last_run_a = run_a;
            run_a = 0;
        end
        if (data_en_b === 1'b1) begin
            valid_b = valid_b + 1;
            prev_vb = last_vb;
            last_vb = cyc;
        end
        if (sclk_b === 1'b0) srun_b = srun_b + 1;
        else if (srun_b != 0) begin
            last_srun_b = srun_b;
            srun_b = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_trig_a();
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag, input int max);
        int n = 0;
        while (busy_a !== 1'b0 && n < max) begin
            step();
            n++;
        end
        check_eq(tag, {31'd0, busy_a}, 32'd0);
    endtask

    task automatic wait_valid_a(input string tag, input int target, input int max);
        int n = 0;
        while (valid_a < target && n < max) begin
            step();
            n++;
        end
        check_eq(tag, valid_a, target);
    endtask

    initial begin
        int base, n;
        rstn = 1'b0;
        cont_en_a = 1'b0; trig_a = 1'b0;
        cont_en_b = 1'b0; trig_b = 1'b0;
        sdata_a = '0; sdata_b = '0; idx_a = 0; idx_b = 0;
        word_a = 14'h0A5C; word_b0 = 14'h0123; word_b1 = 14'h0FED;

        // Reset state
        step();
        check_eq("rst_csn", {31'd0, csn_a}, 32'd1);
        check_eq("rst_sclk", {31'd0, sclk_a}, 32'd1);
        check_eq("rst_data_en", {31'd0, data_en_a}, 32'd0);
        check_eq("rst_data", {20'd0, data_a}, 32'd0);
        check_eq("rst_overrun", {31'd0, overrun_a}, 32'd0);
        check_eq("rst_busy_quiet", {31'd0, busy_a}, 32'd1);
        rstn = 1'b1;
        wait_idle_a("rst_to_idle", 10);

        // Continuous mode, default 32-clk frames
        base = valid_a;
        cont_en_a = 1'b1;
        wait_valid_a("cont_valids", base + 3, 200);
        check_eq("cont_data", {20'd0, data_a}, 32'h0A5C);
        check_eq("cont_period", last_va - prev_va, 32);
        check_eq("cont_csn_low", last_run_a, 28);
        cont_en_a = 1'b0;
        wait_idle_a("cont_stop_idle", 100);

        // Single trigger
        word_a = 14'h05A3;
        base = valid_a;
        pulse_trig_a();
        check_eq("trig_busy", {31'd0, busy_a}, 32'd1);
        check_eq("trig_csn", {31'd0, csn_a}, 32'd0);
        wait_idle_a("trig_idle", 100);
        check_eq("trig_one_valid", valid_a - base, 1);
        check_eq("trig_data", {20'd0, data_a}, 32'h05A3);
        repeat (20) step();
        check_eq("trig_no_more", valid_a - base, 1);
        check_eq("idle_csn", {31'd0, csn_a}, 32'd1);
        check_eq("idle_sclk", {31'd0, sclk_a}, 32'd1);

        // Pending trigger and overrun
        base = valid_a;
        n = ovr_a;
        pulse_trig_a();
        repeat (9) step();
        pulse_trig_a();
        repeat (4) step();
        pulse_trig_a();
        wait_idle_a("ovr_idle", 200);
        check_eq("ovr_valids", valid_a - base, 2);
        check_eq("ovr_pulses", ovr_a - n, 1);
        check_eq("pend_period", last_va - prev_va, 32);

        // Reset mid-frame at h=10
        word_a = 14'h0A5C;
        cont_en_a = 1'b1;
        n = 0;
        while (csn_a !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        check_eq("rst_mid_start", {31'd0, csn_a}, 32'd0);
        repeat (10) step();
        base = valid_a;
        rstn = 1'b0;
        #1;
        check_eq("rst_mid_csn", {31'd0, csn_a}, 32'd1);
        check_eq("rst_mid_sclk", {31'd0, sclk_a}, 32'd1);
        check_eq("rst_mid_data", {20'd0, data_a}, 32'd0);
        step();
        step();
        check_eq("rst_mid_no_valid", valid_a - base, 0);
        rstn = 1'b1;
        n = 0;
        while (data_en_a !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check_eq("rst_resume_lat", n, 32);
        check_eq("rst_resume_data", {20'd0, data_a}, 32'h0A5C);
        cont_en_a = 1'b0;
        wait_idle_a("rst_stop_idle", 100);

        // cont_en dropped at h=5
        word_a = 14'h0789;
        base = valid_a;
        cont_en_a = 1'b1;
        n = 0;
        while (csn_a !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        repeat (5) step();
        cont_en_a = 1'b0;
        wait_idle_a("drop_idle", 100);
        repeat (10) step();
        check_eq("drop_one_valid", valid_a - base, 1);
        check_eq("drop_data", {20'd0, data_a}, 32'h0789);
        check_eq("drop_csn_high", {31'd0, csn_a}, 32'd1);

        // Two lanes, SCLK_DIV=2
        base = valid_b;
        cont_en_b = 1'b1;
        n = 0;
        while (valid_b < base + 2 && n < 300) begin
            step();
            n++;
        end
        check_eq("b_valids", valid_b - base, 2);
        check_eq("b_data", {8'd0, data_b}, 32'h00FED123);
        check_eq("b_period", last_vb - prev_vb, 60);
        check_eq("b_sclk_half", last_srun_b, 2);
        cont_en_b = 1'b0;
        n = 0;
        while (busy_b !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        check_eq("b_idle", {31'd0, busy_b}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
